// File: rtl/ysyx_25020037_axi_rd_slave_if.sv
// AXI4 read-address and read-data channel bundle (AR/R) shared by the read
// masters and the memory-backed read responder.
interface ysyx_25020037_axi_rd_slave_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ysyx_25020037_axi_rd_slave.sv
// AXI4 read responder in front of a synchronous-read word memory: one outstanding
// burst, per-beat range check. Define YSYX_25020037_RDELAY_EN for LFSR wait states.
module ysyx_25020037_axi_rd_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] MEM_SIZE  = 32'h0100_0000
`ifdef YSYX_25020037_RDELAY_EN
   ,parameter logic [7:0]  LFSR_SEED = 8'hA5
`endif
) (
    input  logic                               clk,
    input  logic                               rst,
    ysyx_25020037_axi_rd_slave_if.slave        bus,
    output logic                               mem_ren,
    output logic [31:0]                        mem_raddr,
    input  logic [31:0]                        mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_FETCH,
        S_LOAD,
        S_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  id_q, id_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic        incr_q, incr_d;
    logic        err_q, err_d;
    logic [7:0]  beat_cnt_q, beat_cnt_d;

    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [3:0]  rid_q, rid_d;
    logic        mem_ren_q, mem_ren_d;
    logic [31:0] mem_raddr_q, mem_raddr_d;

`ifdef YSYX_25020037_RDELAY_EN
    logic [7:0]  lfsr_q, lfsr_d;
    logic [1:0]  dly_q, dly_d;
`endif

    logic        start_beat;
    logic [31:0] start_addr;
    logic        start_err;
    logic        issue;
    logic [31:0] issue_addr;
    logic        issue_err;
    logic [31:0] next_addr;

    // Offset arithmetic wraps, so a single unsigned compare covers both bounds.
    function automatic logic in_range(input logic [31:0] word_addr);
        logic [31:0] offset;
        offset = word_addr - BASE_ADDR;
        return offset < MEM_SIZE;
    endfunction

    assign bus.arready = (state_q == S_IDLE);
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rid     = rid_q;
    assign mem_ren     = mem_ren_q;
    assign mem_raddr   = mem_raddr_q;

    // NOTE: every variable gets a default before the case so no path leaves one
    // unassigned; an unassigned path in always_comb would infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        id_d        = id_q;
        len_d       = len_q;
        size_d      = size_q;
        incr_d      = incr_q;
        err_d       = err_q;
        beat_cnt_d  = beat_cnt_q;
        rvalid_d    = rvalid_q;
        rlast_d     = rlast_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rid_d       = rid_q;
        mem_ren_d   = 1'b0;
        mem_raddr_d = mem_raddr_q;
`ifdef YSYX_25020037_RDELAY_EN
        lfsr_d      = lfsr_q;
        dly_d       = dly_q;
`endif
        start_beat  = 1'b0;
        start_addr  = addr_q;
        start_err   = err_q;
        issue       = 1'b0;
        issue_addr  = addr_q;
        issue_err   = err_q;
        next_addr   = incr_q ? addr_q + (32'd1 << size_q) : addr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.arvalid) begin
                    addr_d     = bus.araddr;
                    id_d       = bus.arid;
                    len_d      = bus.arlen;
                    size_d     = bus.arsize;
                    incr_d     = (bus.arburst == 2'b01);
                    err_d      = (bus.arsize > 3'd2) | bus.arburst[1];
                    beat_cnt_d = 8'd0;
                    start_beat = 1'b1;
                    start_addr = bus.araddr;
                    start_err  = err_d;
                end
            end
`ifdef YSYX_25020037_RDELAY_EN
            S_DELAY: begin
                if (dly_q == 2'd1) begin
                    issue = 1'b1;
                end else begin
                    dly_d = dly_q - 2'd1;
                end
            end
`endif
            S_FETCH: begin
                state_d = S_LOAD;
            end
            S_LOAD: begin
                rvalid_d = 1'b1;
                rlast_d  = (beat_cnt_q == len_q);
                rid_d    = id_q;
                if (err_q) begin
                    rdata_d = 32'd0;
                    rresp_d = RESP_SLVERR;
                end else if (!in_range({addr_q[31:2], 2'b00})) begin
                    rdata_d = 32'd0;
                    rresp_d = RESP_DECERR;
                end else begin
                    rdata_d = mem_rdata;
                    rresp_d = RESP_OKAY;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                if (bus.rready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                        addr_d     = next_addr;
                        start_beat = 1'b1;
                        start_addr = next_addr;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new beat either waits in DELAY or goes straight to the memory fetch.
        if (start_beat) begin
`ifdef YSYX_25020037_RDELAY_EN
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (lfsr_q[1:0] == 2'd0) begin
                issue      = 1'b1;
                issue_addr = start_addr;
                issue_err  = start_err;
            end else begin
                state_d = S_DELAY;
                dly_d   = lfsr_q[1:0];
            end
`else
            issue      = 1'b1;
            issue_addr = start_addr;
            issue_err  = start_err;
`endif
        end

        if (issue) begin
            state_d     = S_FETCH;
            mem_ren_d   = in_range({issue_addr[31:2], 2'b00}) & ~issue_err;
            mem_raddr_d = {issue_addr[31:2], 2'b00};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'd0;
            id_q        <= 4'd0;
            len_q       <= 8'd0;
            size_q      <= 3'd0;
            incr_q      <= 1'b0;
            err_q       <= 1'b0;
            beat_cnt_q  <= 8'd0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= 32'd0;
            rresp_q     <= 2'b00;
            rid_q       <= 4'd0;
            mem_ren_q   <= 1'b0;
            mem_raddr_q <= 32'd0;
`ifdef YSYX_25020037_RDELAY_EN
            lfsr_q      <= LFSR_SEED;
            dly_q       <= 2'd0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            len_q       <= len_d;
            size_q      <= size_d;
            incr_q      <= incr_d;
            err_q       <= err_d;
            beat_cnt_q  <= beat_cnt_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            rid_q       <= rid_d;
            mem_ren_q   <= mem_ren_d;
            mem_raddr_q <= mem_raddr_d;
`ifdef YSYX_25020037_RDELAY_EN
            lfsr_q      <= lfsr_d;
            dly_q       <= dly_d;
`endif
        end
    end

endmodule
